// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   MIPS instruction fetch stage. Issues one req/ack fetch at a time, holds the
//   returned word for decode/execute until it is accepted, then selects the next
//   PC from the held instruction plus the decoder's branch/jump and the ALU zero.
//   Optional feature macro: FETCH_PERF_CNT_EN adds fetch/stall performance
//   counters (fetch_count, stall_count) of width CNT_W.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef FETCH_PERF_CNT_EN
  ,parameter int CNT_W = 32
`endif
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic [5:0]        op,
  output logic [31:0]       pc_out,
  output logic [31:0]       pcplus4,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              branch,
  input  logic              zero,
  input  logic              jump
`ifdef FETCH_PERF_CNT_EN
  ,output logic [CNT_W-1:0] fetch_count,
  output logic [CNT_W-1:0]  stall_count
`endif
);

  localparam logic [0:0] S_FETCH = 1'b0;
  localparam logic [0:0] S_HOLD  = 1'b1;

  // The two low address bits are meaningless for word fetches.
  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'd3;

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] next_pc;
  logic [31:0] branch_off;
  logic        accept;

  // pc_q is both the fetch address and, once held, the address of instr_q.
  assign imem_addr   = pc_q;
  assign imem_req    = (state_q == S_FETCH) && !reset;
  assign instr_valid = (state_q == S_HOLD);
  assign instr       = instr_q;
  assign op          = instr_q[31:26];
  assign pc_out      = pc_q;
  assign pcplus4     = pc_q + 32'd4;
  assign accept      = instr_valid && instr_ready;
  assign branch_off  = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  // Next-PC selection from the held instruction; jump outranks a taken branch.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    next_pc = pcplus4;
    if (jump) begin
      next_pc = {pcplus4[31:28], instr_q[25:0], 2'b00};
    end else if (branch && zero) begin
      next_pc = pcplus4 + branch_off;
    end
  end

  // Fetch/hold FSM next-state: capture on ack, advance PC on accept.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = S_HOLD;
        end
      end
      default: begin
        if (instr_ready) begin
          pc_d    = next_pc;
          state_d = S_FETCH;
        end
      end
    endcase
  end

  // State registers; reset abandons any pending fetch or held instruction.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC_ALIGNED;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [CNT_W-1:0] fetch_cnt_q;
  logic [CNT_W-1:0] stall_cnt_q;

  // Performance counters: accepted instructions and un-acked fetch cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (accept) begin
        fetch_cnt_q <= fetch_cnt_q + 1'b1;
      end
      if ((state_q == S_FETCH) && !imem_ack) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`else
  // Without counters the accept strobe has no consumer.
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit
//   Scoreboard bench for instr_fetch_unit. Expected fetch addresses are pushed
//   when an instruction is accepted and popped when the DUT issues its request.
//   Define FETCH_PERF_CNT_EN to also exercise the performance counters.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_ready = 1'b0;
  logic        branch = 1'b0;
  logic        zero = 1'b0;
  logic        jump = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [31:0] pc_out;
  logic [31:0] pcplus4;
  logic        instr_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] exp_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_instr;

  instr_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .op          (op),
    .pc_out      (pc_out),
    .pcplus4     (pcplus4),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .branch      (branch),
    .zero        (zero),
    .jump        (jump)
`ifdef FETCH_PERF_CNT_EN
    ,.fetch_count(fetch_count),
    .stall_count (stall_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  // Hold reset two cycles (optionally with a junk ack), check reset state and
  // the first request afterwards.
  task automatic do_reset(input logic junk_ack);
    reset = 1'b1; imem_ack = junk_ack; imem_rdata = 32'hFFFF_FFFF; instr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0 || op !== 6'h0 ||
        pc_out !== RESET_PC)
      $display("FAIL reset_state: req=%b valid=%b instr=%h op=%b pc_out=%h, want 0 0 0 0 %h",
               imem_req, instr_valid, instr, op, pc_out, RESET_PC);
    else n_pass++;
    reset = 1'b0; imem_ack = 1'b0;
    #1;
    n_total++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC || instr_valid !== 1'b0)
      $display("FAIL post_reset_req: req=%b addr=%h valid=%b, want 1 %h 0",
               imem_req, imem_addr, instr_valid, RESET_PC);
    else n_pass++;
    exp_q.delete();
    exp_q.push_back(RESET_PC);
  endtask

  // Serve one fetch with 'delay' un-acked cycles, then check the held word.
  task automatic fetch(input logic [31:0] rdata, input int delay);
    logic [31:0] exp_addr;
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    n_total++;
    if (imem_req !== 1'b1) $display("FAIL req_timeout: req=%b after %0d cycles, want 1", imem_req, n);
    else n_pass++;
    exp_addr = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    n_total++;
    if (imem_addr !== exp_addr || instr_valid !== 1'b0)
      $display("FAIL fetch_addr: addr=%h valid=%b, want %h 0", imem_addr, instr_valid, exp_addr);
    else n_pass++;
    for (int i = 0; i < delay; i++) begin
      imem_ack = 1'b0;
      @(posedge clk); #1;
      n_total++;
      if (imem_req !== 1'b1 || imem_addr !== exp_addr || instr_valid !== 1'b0)
        $display("FAIL stall_stable: req=%b addr=%h valid=%b, want 1 %h 0",
                 imem_req, imem_addr, instr_valid, exp_addr);
      else n_pass++;
    end
    imem_ack = 1'b1; imem_rdata = rdata;
    @(posedge clk); #1;
    imem_ack = 1'b0; imem_rdata = 32'hCAFE_F00D;
    m_pc = exp_addr; m_instr = rdata;
    n_total++;
    if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== rdata || op !== rdata[31:26] ||
        pc_out !== exp_addr || pcplus4 !== exp_addr + 32'd4)
      $display("FAIL hold_word: valid=%b req=%b instr=%h op=%b pc=%h p4=%h, want 1 0 %h %b %h %h",
               instr_valid, imem_req, instr, op, pc_out, pcplus4,
               rdata, rdata[31:26], exp_addr, exp_addr + 32'd4);
    else n_pass++;
  endtask

  // Keep ready low 'hold' cycles (optionally with spurious acks and noisy
  // branch/jump), then accept with the given controls and push the next PC.
  task automatic accept(input logic br, input logic zr, input logic jp,
                        input int hold, input logic spur);
    logic [31:0] p4, nxt;
    for (int i = 0; i < hold; i++) begin
      instr_ready = 1'b0; imem_ack = spur; imem_rdata = 32'hDEAD_BEEF;
      branch = 1'b1; zero = 1'b1; jump = 1'b1;
      @(posedge clk); #1;
      n_total++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b1 || instr !== m_instr || pc_out !== m_pc)
        $display("FAIL hold_stable: req=%b valid=%b instr=%h pc=%h, want 0 1 %h %h",
                 imem_req, instr_valid, instr, pc_out, m_instr, m_pc);
      else n_pass++;
    end
    imem_ack = 1'b0; branch = br; zero = zr; jump = jp; instr_ready = 1'b1;
    p4 = m_pc + 32'd4;
    if (jp) nxt = {p4[31:28], m_instr[25:0], 2'b00};
    else if (br && zr) nxt = p4 + {{14{m_instr[15]}}, m_instr[15:0], 2'b00};
    else nxt = p4;
    exp_q.push_back(nxt);
    @(posedge clk); #1;
    instr_ready = 1'b0; branch = 1'b0; zero = 1'b0; jump = 1'b0;
    n_total++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1)
      $display("FAIL after_accept: valid=%b req=%b, want 0 1", instr_valid, imem_req);
    else n_pass++;
  endtask

  task automatic expect_addr(input logic [31:0] want);
    n_total++;
    if (imem_addr !== want) $display("FAIL next_addr: addr=%h, want %h", imem_addr, want);
    else n_pass++;
  endtask

  task automatic test_reset();
    do_reset(1'b1);
  endtask

  task automatic test_sequential();
    fetch(32'h2008_0005, 0);
    n_total++;
    if (op !== 6'b001000) $display("FAIL op_field: op=%b, want 001000", op);
    else n_pass++;
    accept(1'b0, 1'b0, 1'b0, 0, 1'b0);
    expect_addr(32'h0000_0004);
  endtask

  task automatic test_branch();
    fetch(32'h0800_0004, 0); accept(1'b0, 1'b0, 1'b1, 0, 1'b0); expect_addr(32'h0000_0010);
    fetch(32'h1000_0003, 0); accept(1'b1, 1'b1, 1'b0, 0, 1'b0); expect_addr(32'h0000_0020);
    fetch(32'h0800_0004, 0); accept(1'b0, 1'b0, 1'b1, 0, 1'b0); expect_addr(32'h0000_0010);
    fetch(32'h1000_0003, 0); accept(1'b1, 1'b0, 1'b0, 0, 1'b0); expect_addr(32'h0000_0014);
    fetch(32'h0800_0004, 0); accept(1'b0, 1'b0, 1'b1, 0, 1'b0); expect_addr(32'h0000_0010);
    fetch(32'h1000_FFFF, 0); accept(1'b1, 1'b1, 1'b0, 0, 1'b0); expect_addr(32'h0000_0010);
  endtask

  task automatic test_stall();
    fetch(32'h0123_4567, 3);
    accept(1'b0, 1'b0, 1'b0, 2, 1'b1);
    expect_addr(32'h0000_0014);
  endtask

  // Climb to 0x3000_0000 with maximal forward branches, then test jumps there.
  task automatic test_jump();
    do_reset(1'b0);
    for (int i = 0; i < 32'h1800; i++) begin
      fetch(32'h1000_7FFF, 0);
      accept(1'b1, 1'b1, 1'b0, 0, 1'b0);
    end
    expect_addr(32'h3000_0000);
    fetch(32'h0800_0040, 0); accept(1'b0, 1'b0, 1'b1, 0, 1'b0); expect_addr(32'h3000_0100);
    fetch(32'h0800_0040, 0); accept(1'b1, 1'b1, 1'b1, 0, 1'b0); expect_addr(32'h3000_0100);
  endtask

  task automatic test_reset_hold_and_wrap();
    fetch(32'h2008_0005, 1);
    do_reset(1'b1);
    fetch(32'h1000_FFFE, 0); accept(1'b1, 1'b1, 1'b0, 0, 1'b0); expect_addr(32'hFFFF_FFFC);
    fetch(32'h0000_0000, 0); accept(1'b0, 1'b0, 1'b0, 1, 1'b0); expect_addr(32'h0000_0000);
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_counters();
    int delays [5] = '{1, 0, 2, 0, 0};
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) begin
      fetch(32'h2008_0005, delays[i]);
      accept(1'b0, 1'b0, 1'b0, 0, 1'b0);
    end
    n_total++;
    if (fetch_count !== 32'd5 || stall_count !== 32'd3)
      $display("FAIL perf_counters: fetch=%0d stall=%0d, want 5 3", fetch_count, stall_count);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_stall();
    test_jump();
    test_reset_hold_and_wrap();
`ifdef FETCH_PERF_CNT_EN
    test_counters();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
